// File: rtl/uart_game_decoder.sv
// Parses the 49-byte ASCII game-state frame popped from the UART RX FIFO and commits it atomically.
// Optional inter-byte gap timeout: define UART_DECODER_TIMEOUT_EN.
module uart_game_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 650_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rd_uart,
    output logic [11:0]           char_x,
    output logic [11:0]           char_y,
    output logic [3:0]            char_hp,
    output logic [3:0]            char_aggro,
    output logic                  flip_h,
    output logic [1:0]            char_class,
    output logic [11:0]           boss_x,
    output logic [11:0]           boss_y,
    output logic [6:0]            boss_hp,
    output logic                  data_valid,
    output logic                  frame_error
);

    if (DATA_WIDTH != 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_game_decoder: DATA_WIDTH must be 8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_HUNT, S_PARSE, S_COMMIT} state_t;

    localparam logic [7:0] CH_C = 8'h43;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [11:0] r_sh_cx, r_sh_cy, r_sh_bx, r_sh_by;
    logic [3:0]  r_sh_hp, r_sh_ag;
    logic        r_sh_fl;
    logic [1:0]  r_sh_cl;
    logic [6:0]  r_sh_bh;
    logic [11:0] r_cx, r_cy, r_bx, r_by;
    logic [3:0]  r_hp, r_ag;
    logic        r_fl;
    logic [1:0]  r_cl;
    logic [6:0]  r_bh;
    logic        r_dv, r_fe;

    logic [7:0]  w_byte;
    logic [3:0]  w_nib;
    logic        w_pop;
    logic        w_is_dig;
    logic        w_known;
    logic [7:0]  w_lit;
    logic [7:0]  w_dmax;
    logic        w_ok;

    assign w_byte  = rx_data[7:0];
    assign w_nib   = w_byte[3:0];
    assign w_pop   = rst_n && !rx_empty && (r_state == S_HUNT || r_state == S_PARSE);
    assign rd_uart = w_pop;

    // Template entry for the current index: either a literal or a digit with an upper bound.
    always_comb begin
        w_is_dig = 1'b0;
        w_known  = 1'b1;
        w_lit    = 8'h00;
        w_dmax   = 8'h3F;
        case (r_idx)
            6'd0:                                          w_lit = CH_C;
            6'd1, 6'd30:                                   w_lit = 8'h58;
            6'd2, 6'd8, 6'd14, 6'd18, 6'd22, 6'd26,
            6'd31, 6'd37, 6'd44:                           w_lit = 8'h3A;
            6'd6, 6'd35:                                   w_lit = 8'h2C;
            6'd7, 6'd36:                                   w_lit = 8'h59;
            6'd12, 6'd16, 6'd20, 6'd24, 6'd28, 6'd41:      w_lit = 8'h7C;
            6'd13, 6'd43:                                  w_lit = 8'h48;
            6'd17:                                         w_lit = 8'h41;
            6'd21:                                         w_lit = 8'h46;
            6'd25:                                         w_lit = 8'h54;
            6'd29, 6'd42:                                  w_lit = 8'h42;
            6'd47:                                         w_lit = 8'h0D;
            6'd48:                                         w_lit = 8'h0A;
            6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd11, 6'd15,
            6'd19, 6'd32, 6'd33, 6'd34, 6'd38, 6'd39,
            6'd40, 6'd46:                                  w_is_dig = 1'b1;
            6'd23: begin w_is_dig = 1'b1; w_dmax = 8'h31; end
            6'd27: begin w_is_dig = 1'b1; w_dmax = 8'h33; end
            6'd45: begin w_is_dig = 1'b1; w_dmax = 8'h37; end
            default:                                       w_known = 1'b0;
        endcase
    end

    assign w_ok = w_known && (w_is_dig ? (w_byte >= 8'h30 && w_byte <= w_dmax)
                                       : (w_byte == w_lit));

`ifdef UART_DECODER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] r_gap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
            r_idx   <= '0;
            r_sh_cx <= '0; r_sh_cy <= '0; r_sh_bx <= '0; r_sh_by <= '0;
            r_sh_hp <= '0; r_sh_ag <= '0; r_sh_fl <= 1'b0; r_sh_cl <= '0; r_sh_bh <= '0;
            r_cx    <= '0; r_cy <= '0; r_bx <= '0; r_by <= '0;
            r_hp    <= '0; r_ag <= '0; r_fl <= 1'b0; r_cl <= '0; r_bh <= '0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
`ifdef UART_DECODER_TIMEOUT_EN
            r_gap   <= '0;
`endif
        end else begin
            r_dv <= 1'b0;
            r_fe <= 1'b0;
`ifdef UART_DECODER_TIMEOUT_EN
            if (w_pop || r_state != S_PARSE)
                r_gap <= '0;
`endif
            case (r_state)
                S_HUNT: begin
                    if (w_pop && w_byte == CH_C) begin
                        r_idx   <= 6'd1;
                        r_state <= S_PARSE;
                    end
                end
                S_PARSE: begin
                    if (w_pop) begin
                        if (w_ok) begin
                            case (r_idx)
                                6'd3, 6'd4, 6'd5:    r_sh_cx <= {r_sh_cx[7:0], w_nib};
                                6'd9, 6'd10, 6'd11:  r_sh_cy <= {r_sh_cy[7:0], w_nib};
                                6'd15:               r_sh_hp <= w_nib;
                                6'd19:               r_sh_ag <= w_nib;
                                6'd23:               r_sh_fl <= w_nib[0];
                                6'd27:               r_sh_cl <= w_nib[1:0];
                                6'd32, 6'd33, 6'd34: r_sh_bx <= {r_sh_bx[7:0], w_nib};
                                6'd38, 6'd39, 6'd40: r_sh_by <= {r_sh_by[7:0], w_nib};
                                6'd45, 6'd46:        r_sh_bh <= {r_sh_bh[2:0], w_nib};
                                default: ;
                            endcase
                            if (r_idx == 6'd48) begin
                                // Publish on the same edge that accepts LF so all fields change together.
                                r_cx    <= r_sh_cx; r_cy <= r_sh_cy; r_bx <= r_sh_bx; r_by <= r_sh_by;
                                r_hp    <= r_sh_hp; r_ag <= r_sh_ag; r_fl <= r_sh_fl;
                                r_cl    <= r_sh_cl; r_bh <= r_sh_bh;
                                r_dv    <= 1'b1;
                                r_idx   <= '0;
                                r_state <= S_COMMIT;
                            end else begin
                                r_idx <= r_idx + 6'd1;
                            end
                        end else begin
                            r_fe <= 1'b1;
                            if (w_byte == CH_C) begin
                                r_idx <= 6'd1;
                            end else begin
                                r_idx   <= '0;
                                r_state <= S_HUNT;
                            end
                        end
                    end
`ifdef UART_DECODER_TIMEOUT_EN
                    else if (r_gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                        r_fe    <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_HUNT;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
`endif
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign char_x      = r_cx;
    assign char_y      = r_cy;
    assign char_hp     = r_hp;
    assign char_aggro  = r_ag;
    assign flip_h      = r_fl;
    assign char_class  = r_cl;
    assign boss_x      = r_bx;
    assign boss_y      = r_by;
    assign boss_hp     = r_bh;
    assign data_valid  = r_dv;
    assign frame_error = r_fe;

endmodule

// File: tb/tb_uart_game_decoder.sv
// Scoreboard bench for uart_game_decoder: directed frames feed a byte FIFO model,
// expected commit/abort events are queued and checked by an independent monitor.
module tb_uart_game_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rd_uart;
    logic [11:0] char_x, char_y, boss_x, boss_y;
    logic [3:0]  char_hp, char_aggro;
    logic        flip_h;
    logic [1:0]  char_class;
    logic [6:0]  boss_hp;
    logic        data_valid, frame_error;

    always #5 clk = ~clk;

    uart_game_decoder #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_uart(rd_uart), .char_x(char_x), .char_y(char_y), .char_hp(char_hp),
        .char_aggro(char_aggro), .flip_h(flip_h), .char_class(char_class),
        .boss_x(boss_x), .boss_y(boss_y), .boss_hp(boss_hp),
        .data_valid(data_valid), .frame_error(frame_error)
    );

    typedef struct { bit err; logic [65:0] v; } exp_t;

    logic [7:0]  fifo[$];
    exp_t        exp_q[$];
    bit          pend = 1'b0;
    int          pops = 0;
    int          checks = 0;
    int          errors = 0;
    logic [65:0] last = '0;
    logic [65:0] act;

    assign act = {char_x, char_y, char_hp, char_aggro, flip_h, char_class, boss_x, boss_y, boss_hp};

    function automatic logic [65:0] pk(input logic [11:0] cx, input logic [11:0] cy,
                                       input logic [3:0] hp, input logic [3:0] ag, input logic fl,
                                       input logic [1:0] cl, input logic [11:0] bx,
                                       input logic [11:0] by, input logic [6:0] bh);
        return {cx, cy, hp, ag, fl, cl, bx, by, bh};
    endfunction

    task automatic chk(input string nm, input logic [65:0] a, input logic [65:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic push_frame(input string body, input int lo, input int hi);
        logic [7:0] b;
        for (int i = lo; i <= hi; i++) begin
            if (i < 47)       b = body[i];
            else if (i == 47) b = 8'h0D;
            else              b = 8'h0A;
            fifo.push_back(b);
        end
    endtask

    task automatic expect_ok(input logic [65:0] v);
        exp_q.push_back('{err: 1'b0, v: v});
        last = v;
    endtask

    task automatic expect_err();
        exp_q.push_back('{err: 1'b1, v: last});
    endtask

    task automatic settle(input int maxc, input bit need_q);
        int n = 0;
        while ((fifo.size() != 0 || pend || (need_q && exp_q.size() != 0)) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout fifo=%0d pending_events=%0d", fifo.size(), exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // RX FIFO model: a pop seen before an edge removes the head at the next negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (pend && fifo.size() != 0) begin
                fifo.delete(0);
                pops++;
            end
            rx_empty = (fifo.size() == 0);
            rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
            #1;
            pend = rd_uart;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (data_valid || frame_error)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event dv=%0b fe=%0b outputs=%h", data_valid, frame_error, act);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind_is_error", 66'(frame_error), 66'(e.err));
                chk(e.err ? "outputs_held_on_error" : "outputs_on_commit", act, e.v);
            end
        end
    end

    localparam string F1  = "CX:1:3,Y:0?0|H:5|A:2|F:1|T:3|BX:200,Y:0<8|BH:64";
    localparam string FQ  = "CX:???,Y:0?0|H:5|A:2|F:1|T:3|BX:200,Y:0<8|BH:64";
    localparam string F2  = "CX:?0?,Y:;=2|H:9|A:?|F:0|T:2|BX:0??,Y:<0>|BH:7?";
    localparam string EBH = "CX:123,Y:0?0|H:5|A:2|F:1|T:3|BX:200,Y:0<8|BH:84";
    localparam string EF  = "CX:1:3,Y:0?0|H:5|A:2|F:2|T:3|BX:200,Y:0<8|BH:64";
    localparam string ET  = "CX:1:3,Y:0?0|H:5|A:2|F:1|T:4|BX:200,Y:0<8|BH:64";
    localparam string ELO = "CX:1:3,Y:/?0|H:5|A:2|F:1|T:3|BX:200,Y:0<8|BH:64";
    localparam string EC  = "CX:1:3,Y:0?0#H:5|A:2|F:1|T:3|BX:200,Y:0<8|BH:64";

    initial begin : main
        logic [65:0] v1, vq, v2;
        int          p0;
        v1 = pk(12'h1A3, 12'h0F0, 4'd5, 4'd2, 1'b1, 2'd3, 12'h200, 12'h0C8, 7'h64);
        vq = pk(12'hFFF, 12'h0F0, 4'd5, 4'd2, 1'b1, 2'd3, 12'h200, 12'h0C8, 7'h64);
        v2 = pk(12'hF0F, 12'hBD2, 4'd9, 4'hF, 1'b0, 2'd2, 12'h0FF, 12'hC0E, 7'h7F);

        repeat (3) @(negedge clk);
        chk("reset_fields", act, 66'd0);
        chk("reset_strobes", 66'({rd_uart, data_valid, frame_error}), 66'd0);
        rst_n = 1'b1;

        // Garbage in HUNT: no events at all.
        fifo.push_back(8'h78); fifo.push_back(8'h7C); fifo.push_back(8'h3A);
        fifo.push_back(8'h30); fifo.push_back(8'h0A);
        settle(200, 1'b1);

        expect_ok(v1);  push_frame(F1, 0, 48);  settle(500, 1'b1);
        expect_ok(vq);  push_frame(FQ, 0, 48);  settle(500, 1'b1);
        expect_err();   push_frame(EBH, 0, 48); settle(500, 1'b1);
        expect_err();   push_frame(EF, 0, 48);  settle(500, 1'b1);
        expect_err();   push_frame(ET, 0, 48);  settle(500, 1'b1);
        expect_err();   push_frame(ELO, 0, 48); settle(500, 1'b1);

        // Corrupt separator, then a clean frame.
        expect_err();   push_frame(EC, 0, 48);
        expect_ok(v2);  push_frame(F2, 0, 48);  settle(500, 1'b1);

        // New 'C' at index 20 restarts the frame.
        p0 = pops;
        expect_err();   push_frame(F1, 0, 19);
        expect_ok(v1);  push_frame(F1, 0, 48);  settle(500, 1'b1);
        chk("pops_inject", 66'(pops - p0), 66'd69);

        // Long stall at index 30.
`ifdef UART_DECODER_TIMEOUT_EN
        expect_err();
`else
        expect_ok(v2);
`endif
        push_frame(F2, 0, 29);
        settle(500, 1'b0);
        repeat (1000) @(negedge clk);
        push_frame(F2, 30, 48);
        settle(500, 1'b1);

        // Reset in the middle of a frame.
        push_frame(F1, 0, 24);
        settle(500, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_fields", act, 66'd0);
        chk("reset_async_strobes", 66'({rd_uart, data_valid, frame_error}), 66'd0);
        last = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(F1, 25, 48);
        settle(500, 1'b1);
        chk("fields_after_reset_tail", act, 66'd0);
        expect_ok(v2);  push_frame(F2, 0, 48);  settle(500, 1'b1);

        chk("scoreboard_drained", 66'(exp_q.size()), 66'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
